serial_subtractor: RTL
======================

// Module: serial_subtractor
//
// PURPOSE
//   Bit-serial WIDTH-bit subtractor: d = a - b - bin, one bit per clock, LSB first.
//   Inverse-direction companion of the combinational ripple adder; trades latency for a
//   single full-subtractor cell.
//   Operands are captured on start/busy handshake; result and borrow-out are presented
//   with a one-cycle done pulse.
//   Sits in the arithmetic datapath alongside the adder and shares its verification style.
//
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>= 2)
//
// PORTS
//   clk     in   1      rising-edge clock
//   reset   in   1      synchronous, active-high reset
//   start   in   1      request; sampled only when not busy
//   a       in   WIDTH  minuend, captured on accepted start
//   b       in   WIDTH  subtrahend, captured on accepted start
//   bin     in   1      borrow-in, captured on accepted start
//   busy    out  1      high while state == RUN
//   done    out  1      one-cycle pulse, result valid
//   d       out  WIDTH  difference; holds until next completion
//   bout    out  1      borrow-out (1 = unsigned underflow); holds with d
//
// BEHAVIOUR
//   Clock and reset:
//   - One clock; reset is synchronous and active-high.
//   - reset=1 at a clk edge: state=IDLE, busy=0, done=0, d=0, bout=0, shift regs=0, cnt=0.
//     It overrides every other input.
//   FSM states:
//   - IDLE: start=1 -> load sa<=a, sb<=b, brw<=bin, cnt<=0, go RUN.
//   - RUN: each cycle compute one bit:
//     - diff_bit = sa[0]^sb[0]^brw
//     - brw <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&brw)
//     - sr <= {diff_bit, sr[WIDTH-1:1]}; sa, sb shift right; cnt<=cnt+1
//     - when cnt==WIDTH-1 (the last bit): d<={diff_bit,sr[WIDTH-1:1]}, bout<=borrow of that bit, go DONE.
//   - DONE: done=1 for exactly this cycle. Then IDLE, or RUN if start=1 (operands loaded as in IDLE).
//   Handshake and timing:
//   - start accepted only in IDLE or DONE; start during RUN is ignored, not queued.
//   - Latency: start accepted at edge N -> busy=1 after edge N.
//     d/bout/done update at edge N+WIDTH; done high for the cycle after edge N+WIDTH.
//   - a, b and bin may change freely after the accepting edge.
//   Arithmetic:
//   - Unsigned modulo 2^WIDTH.
//   - bout=1 iff a < b+bin (as integers).
//   - Equivalently {~bout,d} = {1'b1,a} - b - bin.
//   Result registers:
//   - d/bout are unchanged during RUN; they show the previous result until the new completion.
//   - cnt is $clog2(WIDTH) bits wide; it never wraps inside a run.
//   - Back-to-back: start held high gives one result every WIDTH+1 cycles.
//   Reset mid-RUN aborts: no done pulse, d/bout cleared to 0, returns to IDLE.
//
// TESTING
//   1. reset 2 cycles -> busy=0 done=0 d=8'h00 bout=0.
//   2. a=8'h05 b=8'h03 bin=0, 1-cycle start -> busy 8 cycles; done pulse at edge N+8.
//      Result d=8'h02 bout=0.
//   3. a=8'h00 b=8'h01 bin=0 -> d=8'hFF bout=1.
//      a=8'hFF b=8'hFF bin=1 -> d=8'hFF bout=1.
//      a=8'h80 b=8'h00 bin=1 -> d=8'h7F bout=0.
//   4. start with a=8'h0A b=8'h04, then start pulse with a=8'h01 b=8'h02 at cycle 3 of RUN.
//      Required: the second start is ignored, d=8'h06, exactly one done pulse.
//   5. reset asserted at cycle 4 of RUN -> no done, d=0 bout=0 busy=0 next cycle.
//      A following start with a=8'h09 b=8'h09 -> d=8'h00 bout=0.
//   6. Sweep a,b over 0..10 and bin over 0..1, start held high (back-to-back).
//      Required: every done matches {~bout,d} = {1,a}-b-bin, with one result per 9 cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, d = a - b - bin, LSB first.
// A single full-subtractor cell is reused for WIDTH cycles per operation.
// Ports:
//   i_clk    rising-edge clock
//   i_reset  synchronous, active-high reset
//   i_start  request; accepted only in IDLE or DONE
//   i_a      minuend, captured on accepted start
//   i_b      subtrahend, captured on accepted start
//   i_bin    borrow-in, captured on accepted start
//   o_busy   high while the operation is running
//   o_done   one-cycle pulse, o_d/o_bout valid
//   o_d      difference; holds until the next completion
//   o_bout   borrow-out (1 = unsigned underflow); holds with o_d
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_d,
  output logic             o_bout
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_last;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic             r_brw;
  // Upper WIDTH-1 bits of the result shift register; bit 0 is never needed
  // because the final difference is formed together with the last cell output.
  logic [WIDTH-2:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic             w_diff;
  logic             w_brw_nxt;
  logic [WIDTH-1:0] w_sr_full;

  // Full-subtractor cell on the current LSBs
  assign w_diff    = r_sa[0] ^ r_sb[0] ^ r_brw;
  assign w_brw_nxt = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_brw);
  assign w_sr_full = {w_diff, r_sr};

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_nxt = ST_DONE;
          w_last      = 1'b1;
        end
      end
      ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered status flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand shifters, borrow chain, bit counter and result registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_brw  <= 1'b0;
      r_sr   <= '0;
      r_cnt  <= '0;
      r_d    <= '0;
      r_bout <= 1'b0;
    end else if (w_load) begin
      r_sa  <= i_a;
      r_sb  <= i_b;
      r_brw <= i_bin;
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
      r_brw <= w_brw_nxt;
      r_sr  <= w_sr_full[WIDTH-1:1];
      if (w_last) begin
        // Counter parks at zero instead of wrapping past the last bit
        r_cnt  <= '0;
        r_d    <= w_sr_full;
        r_bout <= w_brw_nxt;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_d    = r_d;
  assign o_bout = r_bout;

endmodule
